// File: rtl/control_arbiter.sv
// Request arbiter issuing opcodes to the datapath over a valid/ready handshake,
// then tracking completion with an optional abort timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no command outstanding; arbitrate req_in each cycle
// ST_ISSUE | opcode presented with op_valid_out, waiting for op_ready_in
// ST_WAIT  | command accepted (busy_out), waiting for done_in or timeout
module control_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int OP_W        = 2,
   parameter int RR_MODE     = 0,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req_in,
   input  logic               op_ready_in,
   input  logic               done_in,
   output logic [OP_W-1:0]    opcode_out,
   output logic               op_valid_out,
   output logic [NUM_REQ-1:0] grant_out,
   output logic               busy_out,
   output logic               timeout_out
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0]    opcode_q, opcode_d;
   logic               valid_q, valid_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   int                 scan_idx;
   logic [IDX_W-1:0]   ptr_next;

   // Scan order starts at the RR pointer in round-robin mode, at 0 otherwise.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (RR_MODE != 0) begin
            scan_idx = (int'(ptr_q) + k) % NUM_REQ;
         end else begin
            scan_idx = k;
         end
         if (!pick_found && req_in[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(scan_idx);
         end
      end
   end

   always_comb begin
      if (int'(win_q) >= NUM_REQ - 1) begin
         ptr_next = '0;
      end else begin
         ptr_next = win_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         cnt_q     <= '0;
         opcode_q  <= '0;
         valid_q   <= 1'b0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         opcode_q  <= opcode_d;
         valid_q   <= valid_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      opcode_d  = opcode_q;
      valid_d   = valid_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            cnt_d  = '0;
            if (pick_found) begin
               win_d    = pick_idx;
               opcode_d = OP_W'(int'(pick_idx) + 1);
               grant_d  = NUM_REQ'(1) << pick_idx;
               valid_d  = 1'b1;
               state_d  = ST_ISSUE;
            end else begin
               opcode_d = '0;
               grant_d  = '0;
               valid_d  = 1'b0;
            end
         end

         // Opcode and grant stay frozen here; req_in is not looked at.
         ST_ISSUE: begin
            if (valid_q && op_ready_in) begin
               valid_d = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               ptr_d   = ptr_next;
               state_d = ST_WAIT;
            end
         end

         // done_in is checked first so a same-cycle completion suppresses the timeout.
         ST_WAIT: begin
            if (done_in) begin
               busy_d   = 1'b0;
               grant_d  = '0;
               opcode_d = '0;
               cnt_d    = '0;
               state_d  = ST_IDLE;
            end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               grant_d   = '0;
               opcode_d  = '0;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d  = ST_IDLE;
            opcode_d = '0;
            valid_d  = 1'b0;
            grant_d  = '0;
            busy_d   = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   assign opcode_out   = opcode_q;
   assign op_valid_out = valid_q;
   assign grant_out    = grant_q;
   assign busy_out     = busy_q;
   assign timeout_out  = timeout_q;

endmodule

// File: tb/tb_control_arbiter.sv
// Directed bench for control_arbiter: a fixed-priority and a round-robin instance
// share the same stimulus, each with an 8-cycle timeout.
module tb_control_arbiter;

   logic       clk;
   logic       reset_n;
   logic [2:0] req_in;
   logic       op_ready_in;
   logic       done_in;

   logic [1:0] fp_opcode, rr_opcode;
   logic       fp_valid, rr_valid;
   logic [2:0] fp_grant, rr_grant;
   logic       fp_busy, rr_busy;
   logic       fp_tmo, rr_tmo;

   int n_chk = 0;
   int n_err = 0;

   control_arbiter #(.NUM_REQ(3), .OP_W(2), .RR_MODE(0), .TIMEOUT_CYC(8)) dut_fp (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_in       (req_in),
      .op_ready_in  (op_ready_in),
      .done_in      (done_in),
      .opcode_out   (fp_opcode),
      .op_valid_out (fp_valid),
      .grant_out    (fp_grant),
      .busy_out     (fp_busy),
      .timeout_out  (fp_tmo)
   );

   control_arbiter #(.NUM_REQ(3), .OP_W(2), .RR_MODE(1), .TIMEOUT_CYC(8)) dut_rr (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_in       (req_in),
      .op_ready_in  (op_ready_in),
      .done_in      (done_in),
      .opcode_out   (rr_opcode),
      .op_valid_out (rr_valid),
      .grant_out    (rr_grant),
      .busy_out     (rr_busy),
      .timeout_out  (rr_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_in      = 3'b000;
      op_ready_in = 1'b0;
      done_in     = 1'b0;
      reset_n     = 1'b0;
      #3;
      reset_n     = 1'b1;
      tick();
   endtask

   initial begin
      logic [1:0] rr_exp [4];
      rr_exp[0] = 2'd1; rr_exp[1] = 2'd2; rr_exp[2] = 2'd3; rr_exp[3] = 2'd1;

      req_in      = 3'b000;
      op_ready_in = 1'b0;
      done_in     = 1'b0;
      reset_n     = 1'b0;
      tick();
      tick();
      chk("rst_opcode", 32'(fp_opcode), 32'd0);
      chk("rst_valid",  32'(fp_valid),  32'd0);
      chk("rst_grant",  32'(fp_grant),  32'd0);
      chk("rst_busy",   32'(fp_busy),   32'd0);
      chk("rst_tmo",    32'(fp_tmo),    32'd0);
      reset_n = 1'b1;
      tick();
      chk("idle_no_req_valid", 32'(rr_valid), 32'd0);

      // Fixed priority with 110: channel 1 wins twice; RR moves on to channel 2.
      do_reset();
      req_in      = 3'b110;
      op_ready_in = 1'b1;
      tick();
      chk("fp_first_opcode", 32'(fp_opcode), 32'd2);
      chk("fp_first_grant",  32'(fp_grant),  32'b010);
      chk("fp_first_valid",  32'(fp_valid),  32'd1);
      tick();
      chk("fp_accept_busy",   32'(fp_busy),   32'd1);
      chk("fp_accept_valid",  32'(fp_valid),  32'd0);
      chk("fp_accept_opcode", 32'(fp_opcode), 32'd2);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      chk("fp_done_busy",   32'(fp_busy),   32'd0);
      chk("fp_done_opcode", 32'(fp_opcode), 32'd0);
      chk("fp_done_grant",  32'(fp_grant),  32'd0);
      tick();
      chk("fp_second_opcode", 32'(fp_opcode), 32'd2);
      chk("rr_second_opcode", 32'(rr_opcode), 32'd3);
      chk("rr_second_grant",  32'(rr_grant),  32'b100);

      // All three requesting: RR rotates 1,2,3,1 while fixed priority stays on 1.
      do_reset();
      req_in      = 3'b111;
      op_ready_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_rot_opcode", 32'(rr_opcode), 32'(rr_exp[k]));
         chk("rr_rot_valid",  32'(rr_valid),  32'd1);
         chk("fp_rot_opcode", 32'(fp_opcode), 32'd1);
         tick();
         done_in = 1'b1;
         tick();
         done_in = 1'b0;
      end

      // Stalled issue with changing requests must hold the command.
      do_reset();
      req_in = 3'b001;
      tick();
      req_in = 3'b100;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_opcode", 32'(fp_opcode), 32'd1);
         chk("stall_grant",  32'(fp_grant),  32'b001);
         chk("stall_valid",  32'(fp_valid),  32'd1);
         chk("stall_busy",   32'(fp_busy),   32'd0);
      end
      op_ready_in = 1'b1;
      tick();
      chk("stall_release_busy",  32'(fp_busy),  32'd1);
      chk("stall_release_valid", 32'(fp_valid), 32'd0);

      // Timeout: pulse exactly 8 edges after the acceptance edge.
      do_reset();
      req_in      = 3'b001;
      op_ready_in = 1'b1;
      tick();
      req_in = 3'b000;
      tick();
      op_ready_in = 1'b0;
      chk("tmo_accept_busy", 32'(fp_busy), 32'd1);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("tmo_wait_pulse", 32'(fp_tmo),  32'd0);
         chk("tmo_wait_busy",  32'(fp_busy), 32'd1);
      end
      tick();
      chk("tmo_pulse",  32'(fp_tmo),    32'd1);
      chk("tmo_busy",   32'(fp_busy),   32'd0);
      chk("tmo_grant",  32'(fp_grant),  32'd0);
      chk("tmo_opcode", 32'(fp_opcode), 32'd0);
      tick();
      chk("tmo_pulse_end", 32'(fp_tmo),   32'd0);
      chk("tmo_idle",      32'(fp_valid), 32'd0);

      // done_in on the last WAIT cycle beats the timeout.
      do_reset();
      req_in      = 3'b001;
      op_ready_in = 1'b1;
      tick();
      req_in = 3'b000;
      tick();
      op_ready_in = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
      end
      chk("race_busy_before", 32'(fp_busy), 32'd1);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      chk("race_busy",  32'(fp_busy), 32'd0);
      chk("race_pulse", 32'(fp_tmo),  32'd0);
      tick();
      chk("race_pulse_after", 32'(fp_tmo), 32'd0);

      // Async reset in WAIT clears outputs before the next edge.
      do_reset();
      req_in      = 3'b001;
      op_ready_in = 1'b1;
      tick();
      tick();
      chk("arst_pre_busy", 32'(fp_busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy",   32'(fp_busy),   32'd0);
      chk("arst_grant",  32'(fp_grant),  32'd0);
      chk("arst_opcode", 32'(fp_opcode), 32'd0);
      chk("arst_tmo",    32'(fp_tmo),    32'd0);
      #2;
      reset_n = 1'b1;
      tick();
      chk("arst_post_opcode", 32'(fp_opcode), 32'd1);
      chk("arst_post_grant",  32'(fp_grant),  32'b001);
      chk("arst_post_valid",  32'(fp_valid),  32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
